// File: rtl/dmem_bus_arbiter_if.sv
// dmem_bus_arbiter_if: CPU/DMA request handshakes and the shared data-memory port
interface dmem_bus_arbiter_if #(
  parameter int WORD_SIZE  = 16,
  parameter int BLOCK_SIZE = 64
);
  logic                  c_req;
  logic                  c_we;
  logic [WORD_SIZE-1:0]  c_addr;
  logic [BLOCK_SIZE-1:0] c_wdata;
  logic [BLOCK_SIZE-1:0] c_rdata;
  logic                  c_done;
  logic                  dma_br;
  logic                  dma_bg;
  logic                  d_req;
  logic                  d_we;
  logic [WORD_SIZE-1:0]  d_addr;
  logic [BLOCK_SIZE-1:0] d_wdata;
  logic [BLOCK_SIZE-1:0] d_rdata;
  logic                  d_done;
  logic                  m_readM;
  logic                  m_writeM;
  logic [WORD_SIZE-1:0]  m_address;
  logic [BLOCK_SIZE-1:0] m_wdata;
  logic [BLOCK_SIZE-1:0] m_rdata;
  modport master (
    input  c_req, c_we, c_addr, c_wdata, dma_br, d_req, d_we, d_addr, d_wdata, m_rdata,
    output c_rdata, c_done, dma_bg, d_rdata, d_done, m_readM, m_writeM, m_address, m_wdata
  );
  modport slave (
    output c_req, c_we, c_addr, c_wdata, dma_br, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  c_rdata, c_done, dma_bg, d_rdata, d_done, m_readM, m_writeM, m_address, m_wdata
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter: shares the data memory port between D-cache and DMA with BR/BG handshake
module dmem_bus_arbiter #(
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input logic                clk,
  input logic                reset_n,
  dmem_bus_arbiter_if.master b
);
  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_OWN, DMA_ACC} state_t;
  state_t     state, state_nx;
  logic [2:0] cnt;
  logic       we, cpu_first, last, acc, start_c, start_d, we_nx;
  assign last    = cnt == 3'd1;
  assign acc     = state == CPU_ACC || state == DMA_ACC;
  assign start_c = state == IDLE && state_nx == CPU_ACC;
  assign start_d = state == DMA_OWN && state_nx == DMA_ACC;
  assign we_nx   = start_c ? b.c_we : b.d_we;
  assign b.dma_bg   = state == DMA_OWN || state == DMA_ACC;
  assign b.m_readM  = acc && !we;
  assign b.m_writeM = acc && we;
  // cpu_first lets a CPU request parked behind a DMA period win the next IDLE decision
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = b.dma_br && !(cpu_first && b.c_req) ? DMA_OWN : b.c_req ? CPU_ACC : IDLE;
      CPU_ACC: state_nx = last ? IDLE : CPU_ACC;
      DMA_OWN: state_nx = b.d_req ? DMA_ACC : b.dma_br ? DMA_OWN : IDLE;
      default: state_nx = last ? DMA_OWN : DMA_ACC;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      we          <= 1'b0;
      cpu_first   <= 1'b0;
      b.m_address <= '0;
      b.m_wdata   <= '0;
      b.c_rdata   <= '0;
      b.d_rdata   <= '0;
      b.c_done    <= 1'b0;
      b.d_done    <= 1'b0;
    end else begin
      state    <= state_nx;
      b.c_done <= state == CPU_ACC && last;
      b.d_done <= state == DMA_ACC && last;
      if (start_c || start_d) begin
        we          <= we_nx;
        b.m_address <= start_c ? b.c_addr : b.d_addr;
        b.m_wdata   <= start_c ? b.c_wdata : b.d_wdata;
        cnt         <= we_nx ? 3'(WRITE_LATENCY) : 3'(READ_LATENCY);
      end else if (acc)
        cnt <= cnt - 3'd1;
      if (state == CPU_ACC && last && !we)
        b.c_rdata <= b.m_rdata;
      if (state == DMA_ACC && last && !we)
        b.d_rdata <= b.m_rdata;
      if (state == DMA_OWN && state_nx == IDLE && b.c_req)
        cpu_first <= 1'b1;
      else if (state == CPU_ACC && last)
        cpu_first <= 1'b0;
    end
  end
endmodule
